// File: rtl/vec_narrow_64_pkg.sv
// Shared constants, state encoding and lane-offset helper for the vector narrowing stage.
package vec_narrow_64_pkg;

  localparam int DEF_DIMENTION    = 64;
  localparam int DEF_WIDTH_ADDEND = 8;
  localparam int DEF_WIDTH_SUM    = DEF_WIDTH_ADDEND + 1;
  localparam int DEF_LANES        = 8;
  localparam int DEF_WIDTH_SHIFT  = 2;

  localparam int BEATS   = DEF_DIMENTION / DEF_LANES;
  localparam int BEAT_W  = $clog2(BEATS);
  localparam int SAT_MAX = (2 ** (DEF_WIDTH_ADDEND - 1)) - 1;
  localparam int SAT_MIN = -(2 ** (DEF_WIDTH_ADDEND - 1));

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PROC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Lane 0 sits in the MSBs, so lane i starts (n-1-i) lanes up from bit 0.
  function automatic int lane_lsb(input int lane, input int n, input int w);
    return (n - 1 - lane) * w;
  endfunction

endpackage

// File: rtl/vec_narrow_64_lane.sv
// One lane of the narrowing datapath: rounding arithmetic right shift, then saturation.
module narrow_lane
  import vec_narrow_64_pkg::*;
#(
  parameter int WIDTH_ADDEND = DEF_WIDTH_ADDEND,
  parameter int WIDTH_SUM    = WIDTH_ADDEND + 1,
  parameter int WIDTH_SHIFT  = DEF_WIDTH_SHIFT
) (
  input  logic signed [WIDTH_SUM-1:0]    x,
  input  logic        [WIDTH_SHIFT-1:0]  s,
  output logic signed [WIDTH_ADDEND-1:0] y,
  output logic                           sat
);

  // One extra bit so the rounding add can never wrap.
  localparam int WE = WIDTH_SUM + 1;
  localparam logic signed [WE-1:0] HI = WE'((2 ** (WIDTH_ADDEND - 1)) - 1);
  localparam logic signed [WE-1:0] LO = WE'(-(2 ** (WIDTH_ADDEND - 1)));

  logic signed [WE-1:0] xe;
  logic signed [WE-1:0] rnd;
  logic signed [WE-1:0] t;

  always_comb begin
    xe  = {x[WIDTH_SUM-1], x};
    rnd = '0;
    if (s != '0) begin
      rnd = WE'(1) << (s - 1'b1);
    end
    t   = (xe + rnd) >>> s;
    y   = t[WIDTH_ADDEND-1:0];
    sat = 1'b0;
    if (t > HI) begin
      y   = HI[WIDTH_ADDEND-1:0];
      sat = 1'b1;
    end else if (t < LO) begin
      y   = LO[WIDTH_ADDEND-1:0];
      sat = 1'b1;
    end
  end

endmodule

// File: rtl/vec_narrow_64.sv
// Narrows a packed vector of signed sums to addend width, LANES lanes per beat,
// with a valid/ready handshake on both sides.
module vec_narrow_64
  import vec_narrow_64_pkg::*;
#(
  parameter int DIMENTION    = DEF_DIMENTION,
  parameter int WIDTH_ADDEND = DEF_WIDTH_ADDEND,
  parameter int WIDTH_SUM    = WIDTH_ADDEND + 1,
  parameter int LANES        = DEF_LANES,
  parameter int WIDTH_SHIFT  = DEF_WIDTH_SHIFT
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [WIDTH_SUM*DIMENTION-1:0]    sum,
  input  logic [WIDTH_SHIFT-1:0]            shift,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [WIDTH_ADDEND*DIMENTION-1:0] narrow,
  output logic [$clog2(DIMENTION):0]        sat_cnt
);

  localparam int NBEATS   = DIMENTION / LANES;
  localparam int NBEAT_W  = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam int CNT_W    = $clog2(DIMENTION) + 1;
  localparam int IN_W     = WIDTH_SUM * DIMENTION;
  localparam int OUT_W    = WIDTH_ADDEND * DIMENTION;
  localparam int CHUNK_S  = LANES * WIDTH_SUM;
  localparam int CHUNK_A  = LANES * WIDTH_ADDEND;
  localparam int IN_BW    = $clog2(IN_W);
  localparam int OUT_BW   = $clog2(OUT_W);

  state_t                   state_reg, state_next;
  logic [IN_W-1:0]          sum_buf_reg;
  logic [WIDTH_SHIFT-1:0]   shift_reg;
  logic [NBEAT_W-1:0]       beat_reg;
  logic [OUT_W-1:0]         narrow_reg;
  logic [CNT_W-1:0]         sat_cnt_reg;

  logic [NBEAT_W-1:0]       rev_beat;
  logic [IN_BW-1:0]         in_base;
  logic [OUT_BW-1:0]        out_base;
  logic [CHUNK_S-1:0]       chunk;
  logic [CHUNK_A-1:0]       lane_y;
  logic [LANES-1:0]         lane_sat;
  logic [CNT_W-1:0]         beat_sat;
  logic                     last_beat;

  // Beat 0 covers the MSB-most chunk, so the part-select base counts down.
  assign rev_beat  = NBEAT_W'(NBEATS - 1) - beat_reg;
  assign in_base   = IN_BW'(rev_beat) * IN_BW'(CHUNK_S);
  assign out_base  = OUT_BW'(rev_beat) * OUT_BW'(CHUNK_A);
  assign chunk     = sum_buf_reg[in_base +: CHUNK_S];
  assign last_beat = (beat_reg == NBEAT_W'(NBEATS - 1));

  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      narrow_lane #(
        .WIDTH_ADDEND (WIDTH_ADDEND),
        .WIDTH_SUM    (WIDTH_SUM),
        .WIDTH_SHIFT  (WIDTH_SHIFT)
      ) u_lane (
        .x   (chunk[lane_lsb(gi, LANES, WIDTH_SUM) +: WIDTH_SUM]),
        .s   (shift_reg),
        .y   (lane_y[lane_lsb(gi, LANES, WIDTH_ADDEND) +: WIDTH_ADDEND]),
        .sat (lane_sat[gi])
      );
    end
  endgenerate

  always_comb begin
    beat_sat = '0;
    for (int i = 0; i < LANES; i++) begin
      beat_sat = beat_sat + CNT_W'(lane_sat[i]);
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (in_valid) state_next = PROC;
      PROC:    if (last_beat) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      sum_buf_reg <= '0;
      shift_reg   <= '0;
      beat_reg    <= '0;
      narrow_reg  <= '0;
      sat_cnt_reg <= '0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            sum_buf_reg <= sum;
            shift_reg   <= shift;
            sat_cnt_reg <= '0;
            beat_reg    <= '0;
          end
        end
        PROC: begin
          narrow_reg[out_base +: CHUNK_A] <= lane_y;
          sat_cnt_reg <= sat_cnt_reg + beat_sat;
          beat_reg    <= last_beat ? '0 : beat_reg + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state_reg == IDLE);
  assign out_valid = (state_reg == DONE);
  assign narrow    = narrow_reg;
  assign sat_cnt   = sat_cnt_reg;

endmodule

// File: tb/tb_vec_narrow_64.sv
// Directed self-checking bench for vec_narrow_64 at default parameters.
module tb_vec_narrow_64;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [575:0] sum = '0;
  logic [1:0]   shift = '0;
  logic         in_ready;
  logic         out_valid;
  logic [511:0] narrow;
  logic [6:0]   sat_cnt;

  int tests = 0;
  int fails = 0;
  logic signed [7:0] exp_l [64];

  vec_narrow_64 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sum       (sum),
    .shift     (shift),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .narrow    (narrow),
    .sat_cnt   (sat_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [575:0] put9(input logic [575:0] v, input int i, input logic [8:0] val);
    logic [575:0] r;
    r = v;
    r[(63 - i) * 9 +: 9] = val;
    return r;
  endfunction

  function automatic logic [575:0] fill9(input logic [8:0] val);
    logic [575:0] r;
    for (int i = 0; i < 64; i++) r[(63 - i) * 9 +: 9] = val;
    return r;
  endfunction

  function automatic logic [511:0] pack8();
    logic [511:0] r;
    for (int i = 0; i < 64; i++) r[(63 - i) * 8 +: 8] = exp_l[i];
    return r;
  endfunction

  task automatic set_exp_all(input logic signed [7:0] val);
    for (int i = 0; i < 64; i++) exp_l[i] = val;
  endtask

  // Offer one vector, let it be accepted on the next edge, then scramble the inputs.
  task automatic send(input logic [575:0] v, input logic [1:0] sh);
    @(negedge clk);
    sum = v;
    shift = sh;
    in_valid = 1'b1;
    tests++;
    if (in_ready !== 1'b1) begin
      fails++;
      $display("FAIL send_in_ready got=%b want=1", in_ready);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    sum = ~v;
    shift = ~sh;
  endtask

  task automatic wait_out(output int n);
    n = 0;
    forever begin
      @(posedge clk);
      #1;
      n++;
      if (out_valid === 1'b1) break;
      if (n >= 40) begin
        tests++;
        fails++;
        $display("FAIL out_valid_timeout got=%b want=1 within 40 cycles", out_valid);
        break;
      end
    end
  endtask

  task automatic pop();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    tests += 4;
    if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    if (narrow !== '0) begin fails++; $display("FAIL reset_narrow got=%h want=0", narrow); end
    if (sat_cnt !== 7'd0) begin fails++; $display("FAIL reset_sat_cnt got=%0d want=0", sat_cnt); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    $display("[TB] reset: in_ready=%b out_valid=%b", in_ready, out_valid);
  endtask

  task automatic test_passthru();
    int n;
    send(fill9(9'sd100), 2'd0);
    wait_out(n);
    set_exp_all(8'sd100);
    tests += 3;
    if (n !== 8) begin fails++; $display("FAIL passthru_latency got=%0d want=8", n); end
    if (narrow !== pack8()) begin fails++; $display("FAIL passthru_narrow got=%h want=%h", narrow, pack8()); end
    if (sat_cnt !== 7'd0) begin fails++; $display("FAIL passthru_sat_cnt got=%0d want=0", sat_cnt); end
    $display("[TB] passthru: latency=%0d sat_cnt=%0d", n, sat_cnt);
    pop();
    tests += 2;
    if (out_valid !== 1'b0) begin fails++; $display("FAIL passthru_pop_out_valid got=%b want=0", out_valid); end
    if (in_ready !== 1'b1) begin fails++; $display("FAIL passthru_pop_in_ready got=%b want=1", in_ready); end
  endtask

  task automatic test_saturate();
    int n;
    logic [575:0] v;
    v = '0;
    v = put9(v, 0, 9'h0FF);
    v = put9(v, 1, 9'h100);
    v = put9(v, 2, 9'd127);
    v = put9(v, 3, 9'h180);
    send(v, 2'd0);
    wait_out(n);
    set_exp_all(8'sd0);
    exp_l[0] = 8'sd127;
    exp_l[1] = -8'sd128;
    exp_l[2] = 8'sd127;
    exp_l[3] = -8'sd128;
    tests += 2;
    if (narrow !== pack8()) begin fails++; $display("FAIL saturate_narrow got=%h want=%h", narrow, pack8()); end
    if (sat_cnt !== 7'd2) begin fails++; $display("FAIL saturate_sat_cnt got=%0d want=2", sat_cnt); end
    $display("[TB] saturate: sat_cnt=%0d", sat_cnt);
    pop();
    // Every lane clamps: the count must reach its full 64.
    send(fill9(9'h0FF), 2'd0);
    wait_out(n);
    set_exp_all(8'sd127);
    tests += 2;
    if (narrow !== pack8()) begin fails++; $display("FAIL sat_all_narrow got=%h want=%h", narrow, pack8()); end
    if (sat_cnt !== 7'd64) begin fails++; $display("FAIL sat_all_sat_cnt got=%0d want=64", sat_cnt); end
    $display("[TB] sat_all: sat_cnt=%0d", sat_cnt);
    pop();
  endtask

  task automatic test_round();
    int n;
    logic [575:0] v;
    v = '0;
    v = put9(v, 0, 9'd3);
    v = put9(v, 1, 9'd5);
    v = put9(v, 2, -9'sd3);
    v = put9(v, 3, -9'sd5);
    v = put9(v, 4, 9'd6);
    send(v, 2'd1);
    wait_out(n);
    set_exp_all(8'sd0);
    exp_l[0] = 8'sd2;
    exp_l[1] = 8'sd3;
    exp_l[2] = -8'sd1;
    exp_l[3] = -8'sd2;
    exp_l[4] = 8'sd3;
    tests += 2;
    if (narrow !== pack8()) begin fails++; $display("FAIL round_narrow got=%h want=%h", narrow, pack8()); end
    if (sat_cnt !== 7'd0) begin fails++; $display("FAIL round_sat_cnt got=%0d want=0", sat_cnt); end
    $display("[TB] round: sat_cnt=%0d", sat_cnt);
    pop();
  endtask

  task automatic test_shift3();
    int n;
    send(fill9(9'h0FF), 2'd3);
    wait_out(n);
    set_exp_all(8'sd32);
    tests += 2;
    if (narrow !== pack8()) begin fails++; $display("FAIL shift3_pos_narrow got=%h want=%h", narrow, pack8()); end
    if (sat_cnt !== 7'd0) begin fails++; $display("FAIL shift3_pos_sat_cnt got=%0d want=0", sat_cnt); end
    $display("[TB] shift3_pos: sat_cnt=%0d", sat_cnt);
    pop();
    send(fill9(9'h100), 2'd3);
    wait_out(n);
    set_exp_all(-8'sd32);
    tests += 2;
    if (narrow !== pack8()) begin fails++; $display("FAIL shift3_neg_narrow got=%h want=%h", narrow, pack8()); end
    if (sat_cnt !== 7'd0) begin fails++; $display("FAIL shift3_neg_sat_cnt got=%0d want=0", sat_cnt); end
    $display("[TB] shift3_neg: sat_cnt=%0d", sat_cnt);
    pop();
  endtask

  task automatic test_back_to_back();
    int n;
    logic [575:0] b;
    send(fill9(9'd100), 2'd1);
    wait_out(n);
    set_exp_all(8'sd50);
    // Lane i of B is 4*(i-32); shift 2 rounds it back to i-32.
    b = '0;
    for (int i = 0; i < 64; i++) b = put9(b, i, 9'((i - 32) * 4));
    @(negedge clk);
    sum = b;
    shift = 2'd2;
    in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      tests += 3;
      if (narrow !== pack8()) begin fails++; $display("FAIL bp_narrow_c%0d got=%h want=%h", c, narrow, pack8()); end
      if (in_ready !== 1'b0) begin fails++; $display("FAIL bp_in_ready_c%0d got=%b want=0", c, in_ready); end
      if (out_valid !== 1'b1) begin fails++; $display("FAIL bp_out_valid_c%0d got=%b want=1", c, out_valid); end
    end
    $display("[TB] backpressure: held 5 cycles sat_cnt=%0d", sat_cnt);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    tests += 2;
    if (out_valid !== 1'b0) begin fails++; $display("FAIL bp_release_out_valid got=%b want=0", out_valid); end
    if (in_ready !== 1'b1) begin fails++; $display("FAIL bp_release_in_ready got=%b want=1", in_ready); end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    shift = 2'd0;
    tests++;
    if (in_ready !== 1'b0) begin fails++; $display("FAIL bp_second_accept got=%b want=0", in_ready); end
    wait_out(n);
    for (int i = 0; i < 64; i++) exp_l[i] = 8'(i - 32);
    tests += 3;
    if (n !== 8) begin fails++; $display("FAIL bp_second_latency got=%0d want=8", n); end
    if (narrow !== pack8()) begin fails++; $display("FAIL bp_second_narrow got=%h want=%h", narrow, pack8()); end
    if (sat_cnt !== 7'd0) begin fails++; $display("FAIL bp_second_sat_cnt got=%0d want=0", sat_cnt); end
    $display("[TB] back_to_back: second vector sat_cnt=%0d", sat_cnt);
    pop();
  endtask

  task automatic test_reset_mid();
    int n;
    logic [575:0] v;
    send(fill9(9'h0FF), 2'd0);
    repeat (4) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    tests += 3;
    if (out_valid !== 1'b0) begin fails++; $display("FAIL abort_out_valid got=%b want=0", out_valid); end
    if (in_ready !== 1'b1) begin fails++; $display("FAIL abort_in_ready got=%b want=1", in_ready); end
    if (sat_cnt !== 7'd0) begin fails++; $display("FAIL abort_sat_cnt got=%0d want=0", sat_cnt); end
    @(negedge clk);
    rst_n = 1'b1;
    v = put9('0, 0, 9'h0FF);
    send(v, 2'd0);
    wait_out(n);
    set_exp_all(8'sd0);
    exp_l[0] = 8'sd127;
    tests += 2;
    if (narrow !== pack8()) begin fails++; $display("FAIL after_abort_narrow got=%h want=%h", narrow, pack8()); end
    if (sat_cnt !== 7'd1) begin fails++; $display("FAIL after_abort_sat_cnt got=%0d want=1", sat_cnt); end
    $display("[TB] reset_mid: next vector sat_cnt=%0d", sat_cnt);
    pop();
  endtask

  initial begin
    test_reset();
    test_passthru();
    test_saturate();
    test_round();
    test_shift3();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/vec_narrow_64.md
Name: vec_narrow_64

Overview:
- Narrows a packed signed vector of DIMENTION sums, each WIDTH_SUM bits, back to WIDTH_ADDEND bits per lane, so the result can feed the next add stage at operand width.
- Per lane: rounding arithmetic right shift, then saturation.
- Processes LANES lanes per cycle and is time-multiplexed over DIMENTION/LANES cycles.
- Uses a valid/ready handshake on both sides and sits directly downstream of the 64-lane vector adder.

Parameters:
- DIMENTION, 64, number of lanes per vector.
- WIDTH_ADDEND, 8, output lane width (signed).
- WIDTH_SUM, WIDTH_ADDEND+1, input lane width (signed).
- LANES, 8, lanes processed per cycle. Must divide DIMENTION.
- WIDTH_SHIFT, 2, width of the shift-amount input (shift range 0..3).

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  input vector valid.
- in_ready  output  1  block can accept a vector.
- sum  input  WIDTH_SUM*DIMENTION  packed signed lanes; lane 0 in the MSBs.
- shift  input  WIDTH_SHIFT  right-shift amount, sampled with the vector.
- out_valid  output  1  narrowed vector valid.
- out_ready  input  1  consumer accepts the vector.
- narrow  output  WIDTH_ADDEND*DIMENTION  packed signed result; lane 0 in the MSBs.
- sat_cnt  output  $clog2(DIMENTION)+1  number of lanes saturated in this vector.

Behaviour:
- Interface (already decided): one clock clk; reset rst_n is asynchronous and active-low.
- Reset values: state=IDLE, in_ready=1, out_valid=0, narrow=0, sat_cnt=0, beat counter=0.
- FSM states and transitions:
  - IDLE: in_ready=1. On in_valid&in_ready, capture sum and shift into the input buffer, clear sat_cnt, beat=0, go to PROC.
  - PROC: in_ready=0. Each cycle, process lanes beat*LANES .. beat*LANES+LANES-1. Write their results into the narrow register and add the number saturated in this beat to sat_cnt. beat increments. After beat DIMENTION/LANES-1, go to DONE.
  - DONE: out_valid=1, with narrow and sat_cnt held stable. On out_ready, go to IDLE with out_valid=0 next cycle.
- Latency: the handshake edge starts PROC. out_valid rises DIMENTION/LANES cycles after the accept edge (8 cycles at defaults).
- Throughput: one vector per DIMENTION/LANES+2 cycles minimum.
- in_valid while not in IDLE is ignored. The upstream holds it until in_ready.
- out_valid, once high, stays high with stable data until out_ready, whatever in_valid does.
- Per-lane arithmetic, with x = signed WIDTH_SUM lane:
  - shift=0: y = x.
  - shift=s>0: y = (x + 2^(s-1)) >>> s, computed at WIDTH_SUM+1 bits so the rounding add cannot overflow. This is round-half-up toward +inf.
  - Saturate y to [-2^(WIDTH_ADDEND-1), 2^(WIDTH_ADDEND-1)-1].
  - A lane counts in sat_cnt iff clamping changed its value.
- Output register bits for lanes not yet processed keep their previous vector's value. narrow is only meaningful while out_valid=1.
- If rst_n is asserted mid-PROC or mid-DONE: immediate return to the reset values. The partial vector is discarded.
- The shift captured at accept is used for all beats. A change on the shift port during PROC has no effect.

Decomposition:
- Shared package holds:
  - state encoding enum (IDLE, PROC, DONE);
  - localparams BEATS = DIMENTION/LANES, BEAT_W = $clog2(BEATS), SAT_MAX = 2^(WIDTH_ADDEND-1)-1, SAT_MIN = -2^(WIDTH_ADDEND-1).
- One combinational sub-module, narrow_lane, handles a single lane.
  - Ports: x[WIDTH_SUM], s[WIDTH_SHIFT] -> y[WIDTH_ADDEND], sat.
  - Instantiated LANES times in a generate loop.
  - Lane selection by beat uses an indexed part-select on the captured buffer.

Test Plan:
- All lanes = 9'sd100, shift=0 -> all lanes 8'sd100, sat_cnt=0. out_valid rises 8 cycles after the accept edge.
- Lane 0 = 255, lane 1 = -256, lane 2 = 127, lane 3 = -128, rest 0, shift=0 -> 127, -128, 127, -128, 0..., sat_cnt=2.
- Lanes = 3, 5, -3, -5, 6, shift=1 -> 2, 3, -1, -2, 3 (round-half-up), sat_cnt=0.
- All lanes = 255, shift=3 -> (255+4)>>>3 = 32 in every lane, sat_cnt=0. All lanes = -256, shift=3 -> -32.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid while in_valid=1 with a new vector.
  - Required: narrow stable, in_ready=0.
  - After out_ready=1: return to IDLE, then the second vector is accepted with a correct result.
- Assert rst_n=0 at PROC beat 4 -> out_valid=0, in_ready=1 asynchronously. A following vector completes with no residue from the aborted one in sat_cnt.
